// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (F) and load/store (D), one access in flight.
// Optional build macro ARB_ROUND_ROBIN_EN alternates priority on contention; default is fixed D-over-F.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic                f_gnt,
  output logic                f_rvalid,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t     state, state_nxt;
  logic [1:0] lat_cnt, lat_cnt_nxt;
  logic       owner, owner_nxt;
  logic       d_wins;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;
  assign d_wins = d_req & (~f_req | ~last_owner);
  always_ff @(posedge clk or posedge reset)
    if (reset) last_owner <= 1'b0;
    else if (mem_en) last_owner <= d_gnt;
`else
  assign d_wins = d_req;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
      owner   <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      owner   <= owner_nxt;
    end
  // owner: 0 = F, 1 = D; reads return on the owner's port only
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    owner_nxt   = owner;
    f_gnt       = 1'b0;
    d_gnt       = 1'b0;
    f_rvalid    = 1'b0;
    d_rvalid    = 1'b0;
    if (!reset && state == IDLE) begin
      d_gnt = d_wins;
      f_gnt = f_req & ~d_wins;
      if (f_gnt || (d_gnt && !d_we)) begin
        state_nxt   = RD_WAIT;
        lat_cnt_nxt = 2'(READ_LATENCY - 1);
        owner_nxt   = d_gnt;
      end
    end else if (!reset) begin
      f_rvalid    = lat_cnt == 2'd0 && !owner;
      d_rvalid    = lat_cnt == 2'd0 && owner;
      state_nxt   = lat_cnt == 2'd0 ? IDLE : RD_WAIT;
      lat_cnt_nxt = lat_cnt == 2'd0 ? lat_cnt : lat_cnt - 2'd1;
    end
  end
  assign mem_en    = f_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr : f_addr;
  assign mem_wdata = d_wdata;
  assign mem_wstrb = mem_we ? d_wstrb : '0;
  assign f_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign busy      = !reset && state == RD_WAIT;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; four DUTs with READ_LATENCY 1..4 share stimulus, sel picks the observed one.
module tb_mem_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0] d_wstrb = '0;
  logic f_gnt_a [1:4], d_gnt_a [1:4], f_rvalid_a [1:4], d_rvalid_a [1:4];
  logic mem_en_a [1:4], mem_we_a [1:4], busy_a [1:4];
  logic [31:0] f_rdata_a [1:4], d_rdata_a [1:4], mem_addr_a [1:4], mem_wdata_a [1:4];
  logic [3:0] mem_wstrb_a [1:4];
  int sel = 1, cyc = 0, checks = 0, errors = 0;
  logic f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] f_rdata, d_rdata, mem_addr;
  typedef struct { int cyc; int kind; logic [31:0] data; logic we; } ev_t;
  ev_t exp_q [$];
  string nm [4] = '{"f_gnt", "d_gnt", "f_rvalid", "d_rvalid"};
  assign f_gnt    = f_gnt_a[sel];
  assign d_gnt    = d_gnt_a[sel];
  assign f_rvalid = f_rvalid_a[sel];
  assign d_rvalid = d_rvalid_a[sel];
  assign mem_en   = mem_en_a[sel];
  assign mem_we   = mem_we_a[sel];
  assign busy     = busy_a[sel];
  assign f_rdata  = f_rdata_a[sel];
  assign d_rdata  = d_rdata_a[sel];
  assign mem_addr = mem_addr_a[sel];
  function automatic logic [31:0] pat(input logic [31:0] a);
    return a == 32'h10 ? 32'hDEADBEEF : 32'hC0DE0000 | a;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction
  for (genvar g = 1; g <= 4; g++) begin : g_dut
    logic [31:0] rd_q, st_a, st_d;
    logic st_v;
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(g)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt_a[g]), .f_rvalid(f_rvalid_a[g]), .f_rdata(f_rdata_a[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt_a[g]), .d_rvalid(d_rvalid_a[g]), .d_rdata(d_rdata_a[g]),
      .mem_en(mem_en_a[g]), .mem_we(mem_we_a[g]), .mem_addr(mem_addr_a[g]),
      .mem_wdata(mem_wdata_a[g]), .mem_wstrb(mem_wstrb_a[g]), .mem_rdata(rd_q), .busy(busy_a[g])
    );
    // memory model: one stored word over a fixed pattern; read data held from the cycle after mem_en
    always @(posedge clk or posedge reset)
      if (reset) st_v <= 1'b0;
      else if (mem_en_a[g] && mem_we_a[g]) begin
        st_v <= 1'b1;
        st_a <= mem_addr_a[g];
        st_d <= merge(pat(mem_addr_a[g]), mem_wdata_a[g], mem_wstrb_a[g]);
      end
    always @(posedge clk)
      if (mem_en_a[g] && !mem_we_a[g]) rd_q <= (st_v && st_a == mem_addr_a[g]) ? st_d : pat(mem_addr_a[g]);
  end
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [3:0] ev;
    logic [31:0] act;
    ev_t e;
    ev = {d_rvalid, f_rvalid, d_gnt, f_gnt};
    for (int k = 0; k < 4; k++) if (ev[k]) begin
      act = k < 2 ? mem_addr : (k == 2 ? f_rdata : d_rdata);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected %s at cycle %0d data %h", nm[k], cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc || e.data !== act || (k < 2 && e.we !== mem_we)) begin
          errors++;
          $display("FAIL event: got %s cyc %0d data %h we %b, expected %s cyc %0d data %h we %b",
                   nm[k], cyc, act, mem_we, nm[e.kind], e.cyc, e.data, e.we);
        end
      end
    end
    checks++;
    if (mem_en !== (f_gnt | d_gnt) || (f_gnt & d_gnt) || (mem_we & ~d_gnt)) begin
      errors++;
      $display("FAIL strobes at cycle %0d: mem_en %b mem_we %b f_gnt %b d_gnt %b", cyc, mem_en, mem_we, f_gnt, d_gnt);
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic push(input int c, input int k, input logic [31:0] d, input logic we);
    exp_q.push_back('{c, k, d, we});
  endtask
  task automatic rst_all();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    #2;
    chk("rst_f_gnt", 32'(f_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step(1);
    reset = 1'b0;
    // single fetch, latency 2
    sel = 2; f_addr = 32'h10; f_req = 1'b1;
    push(cyc, 0, 32'h10, 1'b0); push(cyc + 2, 2, 32'hDEADBEEF, 1'b0);
    #1 chk("t1_busy_T0", 32'(busy), 0);
    step(1); f_req = 1'b0; chk("t1_busy_T1", 32'(busy), 1);
    step(1); chk("t1_busy_T2", 32'(busy), 1);
    step(1); chk("t1_busy_T3", 32'(busy), 0);
    // store then load, latency 3
    rst_all(); sel = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    push(cyc, 1, 32'h40, 1'b1);
    step(1); d_we = 1'b0;
    push(cyc, 1, 32'h40, 1'b0); push(cyc + 3, 3, 32'h12345678, 1'b0);
    step(1); d_req = 1'b0;
    step(3);
    // contention, latency 1
    rst_all(); sel = 1;
    f_req = 1'b1; f_addr = 32'h28; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    push(cyc, 1, 32'h24, 1'b0); push(cyc + 1, 3, 32'hC0DE0024, 1'b0);
    push(cyc + 2, 0, 32'h28, 1'b0); push(cyc + 3, 2, 32'hC0DE0028, 1'b0);
    step(1); d_req = 1'b0;
    step(2); f_req = 1'b0;
    step(1);
    // blocking, latency 4
    rst_all(); sel = 4;
    f_req = 1'b1; f_addr = 32'h2C;
    push(cyc, 0, 32'h2C, 1'b0); push(cyc + 4, 2, 32'hC0DE002C, 1'b0);
    step(1); f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    push(cyc + 4, 1, 32'h30, 1'b0); push(cyc + 8, 3, 32'hC0DE0030, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_mem_en_blocked", 32'(mem_en), 0);
      chk("t4_d_gnt_blocked", 32'(d_gnt), 0);
      step(1);
    end
    step(1); d_req = 1'b0;
    step(4);
    // reset mid-read, latency 3
    rst_all(); sel = 3;
    f_req = 1'b1; f_addr = 32'h34;
    push(cyc, 0, 32'h34, 1'b0);
    step(1); f_req = 1'b0; reset = 1'b1;
    #1;
    chk("t5_busy_in_reset", 32'(busy), 0);
    chk("t5_f_rvalid_in_reset", 32'(f_rvalid), 0);
    step(1); reset = 1'b0; f_req = 1'b1; f_addr = 32'h38;
    push(cyc, 0, 32'h38, 1'b0); push(cyc + 3, 2, 32'hC0DE0038, 1'b0);
    step(1); f_req = 1'b0;
    step(3);
    // continuous contention, latency 1
    rst_all(); sel = 1;
    f_req = 1'b1; f_addr = 32'h28; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    push(cyc, 1, 32'h24, 1'b0); push(cyc + 1, 3, 32'hC0DE0024, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
    push(cyc + 2, 0, 32'h28, 1'b0); push(cyc + 3, 2, 32'hC0DE0028, 1'b0);
`else
    push(cyc + 2, 1, 32'h24, 1'b0); push(cyc + 3, 3, 32'hC0DE0024, 1'b0);
`endif
    push(cyc + 4, 1, 32'h24, 1'b0); push(cyc + 5, 3, 32'hC0DE0024, 1'b0);
    step(5); f_req = 1'b0; d_req = 1'b0;
    step(2);
    chk("pending_events", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
